round_sched: RTL and testbench

Four-requester scheduler in front of the shared mantissa round/normalize datapath of the multi-precision PE. Arbitrates round-robin among PE lanes presenting unrounded 106-bit mantissa products, pipelines the winner through the rounder, applies the returned exponent delta, and returns the result with a requester tag under valid/ready backpressure. It is the single point through which every PE lane reaches the rounder.

---
 rtl/round_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_round_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sched.sv
// round_sched: four-lane round-robin front end to the shared mantissa round/normalize datapath.
// Optional exponent overflow saturation is enabled by defining ROUND_SCHED_OVF_EN.

module round_sched #(
   parameter int WIDTH = 106,
   parameter int EXPW  = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req_valid,
   output logic [3:0]           req_ready,
   input  logic [4*WIDTH-1:0]   req_man,
   input  logic [4*EXPW-1:0]    req_exp,
   input  logic [7:0]           req_prec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_id,
   output logic [51:0]          out_norm,
   output logic [EXPW-1:0]      out_exp,
   output logic [1:0]           out_prec,
   output logic                 out_err,
   output logic                 out_ovf
);

   localparam logic [1:0] PREC_FP16 = 2'b00;
   localparam logic [1:0] PREC_FP32 = 2'b01;
   localparam logic [1:0] PREC_FP64 = 2'b10;
   localparam logic [1:0] PREC_ERR  = 2'b11;

   logic [1:0]       ptr;
   logic             s1_valid;
   logic [1:0]       s1_id;
   logic [WIDTH-1:0] s1_man;
   logic [EXPW-1:0]  s1_exp;
   logic [1:0]       s1_prec;

   logic             grant_hit;
   logic [1:0]       grant_id;
   logic [1:0]       cand;
   logic             grant_take;
   logic             s1_open;
   logic             s2_load;
   logic [WIDTH-1:0] grant_man;
   logic [EXPW-1:0]  grant_exp;
   logic [1:0]       grant_prec;

   logic             msb;
   logic             nxt;
   logic             lead;
   logic [WIDTH-1:0] shifted;
   logic [51:0]      frac64;
   logic [22:0]      frac32;
   logic [9:0]       frac16;
   logic             rb64;
   logic             rb32;
   logic             rb16;
   logic [53:0]      sum64;
   logic [24:0]      sum32;
   logic [11:0]      sum16;
   logic             carry;
   logic [1:0]       delta;
   logic [51:0]      rnd_norm;
   logic             rnd_err;
   logic [EXPW:0]    exp_sum;
   logic [EXPW-1:0]  rnd_exp;

   // Round-robin scan starting at ptr; first asserted lane wins.
   always_comb begin
      grant_hit = 1'b0;
      grant_id  = 2'd0;
      cand      = ptr;
      for (int k = 0; k < 4; k++) begin
         cand = ptr + 2'(k);
         if (!grant_hit && req_valid[cand]) begin
            grant_hit = 1'b1;
            grant_id  = cand;
         end
      end
   end

   always_comb begin
      grant_man  = req_man[int'(grant_id)*WIDTH +: WIDTH];
      grant_exp  = req_exp[int'(grant_id)*EXPW +: EXPW];
      grant_prec = req_prec[int'(grant_id)*2 +: 2];
   end

   assign s2_load    = s1_valid && (!out_valid || out_ready);
   assign s1_open    = !s1_valid || s2_load;
   assign grant_take = grant_hit && s1_open && !rst;
   assign req_ready  = grant_take ? (4'b0001 << grant_id) : 4'b0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= 2'd0;
         s1_valid <= 1'b0;
         s1_id    <= 2'd0;
         s1_man   <= '0;
         s1_exp   <= '0;
         s1_prec  <= 2'd0;
      end else begin
         if (s1_open) begin
            s1_valid <= grant_take;
         end
         if (grant_take) begin
            ptr     <= grant_id + 2'd1;
            s1_id   <= grant_id;
            s1_man  <= grant_man;
            s1_exp  <= grant_exp;
            s1_prec <= grant_prec;
         end
      end
   end

   // Drop the leading one (at the MSB or one below) so the fraction sits at the top of shifted.
   always_comb begin
      msb     = s1_man[WIDTH-1];
      nxt     = s1_man[WIDTH-2];
      lead    = msb || nxt;
      shifted = msb ? (s1_man << 1) : (s1_man << 2);
      frac64  = shifted[WIDTH-1 -: 52];
      frac32  = shifted[WIDTH-1 -: 23];
      frac16  = shifted[WIDTH-1 -: 10];
      rb64    = shifted[WIDTH-53];
      rb32    = shifted[WIDTH-24];
      rb16    = shifted[WIDTH-11];
      sum64   = {2'b01, frac64} + {53'd0, rb64};
      sum32   = {2'b01, frac32} + {24'd0, rb32};
      sum16   = {2'b01, frac16} + {11'd0, rb16};
   end

   always_comb begin
      carry    = 1'b0;
      rnd_norm = '0;
      rnd_err  = 1'b0;
      case (s1_prec)
         PREC_FP64: begin
            carry    = sum64[53];
            rnd_norm = carry ? sum64[52:1] : sum64[51:0];
         end
         PREC_FP32: begin
            carry    = sum32[24];
            rnd_norm = {29'd0, (carry ? sum32[23:1] : sum32[22:0])};
         end
         PREC_FP16: begin
            carry    = sum16[11];
            rnd_norm = {42'd0, (carry ? sum16[10:1] : sum16[9:0])};
         end
         default: begin
            rnd_err = 1'b1;
         end
      endcase
      if (!lead || rnd_err) begin
         carry    = 1'b0;
         rnd_norm = '0;
      end
      delta = rnd_err ? 2'd0 : ({1'b0, msb} + {1'b0, carry});
      exp_sum = {1'b0, s1_exp} + (EXPW+1)'(delta);
   end

`ifdef ROUND_SCHED_OVF_EN
   logic [EXPW:0]   exp_max;
   logic [EXPW-1:0] exp_sat;
   logic            rnd_ovf;

   // Saturate to the all-ones exponent of the result format when the sum passes max normal.
   always_comb begin
      exp_max = (EXPW+1)'(2046);
      exp_sat = EXPW'(2047);
      case (s1_prec)
         PREC_FP32: begin
            exp_max = (EXPW+1)'(254);
            exp_sat = EXPW'(255);
         end
         PREC_FP16: begin
            exp_max = (EXPW+1)'(30);
            exp_sat = EXPW'(31);
         end
         default: begin
            exp_max = (EXPW+1)'(2046);
            exp_sat = EXPW'(2047);
         end
      endcase
      rnd_ovf = (s1_prec != PREC_ERR) && (exp_sum > exp_max);
      rnd_exp = rnd_ovf ? exp_sat : exp_sum[EXPW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_ovf <= 1'b0;
      end else if (s2_load) begin
         out_ovf <= rnd_ovf;
      end
   end
`else
   assign rnd_exp = exp_sum[EXPW-1:0];
   assign out_ovf = 1'b0;
`endif

   // Output register; contents only change on a load, so data holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_id    <= 2'd0;
         out_norm  <= '0;
         out_exp   <= '0;
         out_prec  <= 2'd0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_id    <= s1_id;
         out_norm  <= rnd_norm;
         out_exp   <= rnd_exp;
         out_prec  <= s1_prec;
         out_err   <= rnd_err;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_round_sched.sv
// tb_round_sched: directed scoreboard bench for round_sched; expected results are queued
// at issue and a negedge monitor compares them against each delivered result.

module tb_round_sched;

   localparam int WIDTH = 106;
   localparam int EXPW  = 11;

   logic                 clk;
   logic                 rst;
   logic [3:0]           req_valid;
   logic [3:0]           req_ready;
   logic [4*WIDTH-1:0]   req_man;
   logic [4*EXPW-1:0]    req_exp;
   logic [7:0]           req_prec;
   logic                 out_valid;
   logic                 out_ready;
   logic [1:0]           out_id;
   logic [51:0]          out_norm;
   logic [EXPW-1:0]      out_exp;
   logic [1:0]           out_prec;
   logic                 out_err;
   logic                 out_ovf;

   typedef struct {
      logic [1:0]      id;
      logic [51:0]     norm;
      logic [EXPW-1:0] exp;
      logic [1:0]      prec;
      logic            err;
      logic            ovf;
   } result_t;

   result_t sb[$];
   int      out_stamp[$];
   int      tests_run = 0;
   int      tests_failed = 0;
   int      cyc = 0;
   result_t mon_r;

   round_sched #(.WIDTH(WIDTH), .EXPW(EXPW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_man   (req_man),
      .req_exp   (req_exp),
      .req_prec  (req_prec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .out_norm  (out_norm),
      .out_exp   (out_exp),
      .out_prec  (out_prec),
      .out_err   (out_err),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: a result transfers at the next rising edge when valid and ready are both high here.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         out_stamp.push_back(cyc);
         if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_output: actual id %0d exp %0d, required no output", out_id, out_exp);
         end else begin
            mon_r = sb.pop_front();
            check_output("out_id",   64'(out_id),   64'(mon_r.id));
            check_output("out_norm", 64'(out_norm), 64'(mon_r.norm));
            check_output("out_exp",  64'(out_exp),  64'(mon_r.exp));
            check_output("out_prec", 64'(out_prec), 64'(mon_r.prec));
            check_output("out_err",  64'(out_err),  64'(mon_r.err));
            check_output("out_ovf",  64'(out_ovf),  64'(mon_r.ovf));
         end
      end
   end

   function automatic result_t mk(input logic [1:0] id, input logic [51:0] norm, input int exp,
                                  input logic [1:0] prec, input logic err, input logic ovf);
      result_t r;
      r.id   = id;
      r.norm = norm;
      r.exp  = EXPW'(exp);
      r.prec = prec;
      r.err  = err;
      r.ovf  = ovf;
      return r;
   endfunction

   task automatic set_lane(input int lane, input logic [WIDTH-1:0] man, input int exp, input logic [1:0] prec);
      req_man[lane*WIDTH +: WIDTH] = man;
      req_exp[lane*EXPW +: EXPW]   = EXPW'(exp);
      req_prec[lane*2 +: 2]        = prec;
   endtask

   // Returns one time unit after the accepting edge.
   task automatic apply_stimulus(input int lane, input logic [WIDTH-1:0] man, input int exp,
                                 input logic [1:0] prec, input bit push, input result_t r);
      bit got;
      got = 1'b0;
      if (push) sb.push_back(r);
      set_lane(lane, man, exp, prec);
      req_valid[lane] = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (req_ready[lane]) got = 1'b1;
      end
      check_output("accept", 64'(got), 64'(1));
      @(posedge clk);
      #1;
      req_valid[lane] = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      check_output("drain", 64'(sb.size()), 64'(0));
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 4'b0000;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_output("rst_req_ready", 64'(req_ready), 64'(0));
      check_output("rst_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_stamp.delete();
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [WIDTH-1:0] m;
      int cnt;
      int span;
      result_t dummy;

      rst       = 1'b1;
      req_valid = 4'b0000;
      req_man   = '0;
      req_exp   = '0;
      req_prec  = '0;
      out_ready = 1'b1;
      dummy     = mk(2'd0, 52'd0, 0, 2'b00, 1'b0, 1'b0);

      do_reset();
      check_output("rst_out_id",   64'(out_id),   64'(0));
      check_output("rst_out_norm", 64'(out_norm), 64'(0));
      check_output("rst_out_exp",  64'(out_exp),  64'(0));
      check_output("rst_out_prec", 64'(out_prec), 64'(0));
      check_output("rst_out_err",  64'(out_err),  64'(0));
      check_output("rst_out_ovf",  64'(out_ovf),  64'(0));

      // FP64, leading one at the top, nothing to round: exponent bumps by one.
      m = '0; m[105] = 1'b1;
      apply_stimulus(0, m, 1000, 2'b10, 1'b1, mk(2'd0, 52'd0, 1001, 2'b10, 1'b0, 1'b0));
      check_output("lat_after_n", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      check_output("lat_after_n1", 64'(out_valid), 64'(1));
      wait_drain();

      // FP32, top bit set and all-ones fraction with round bit: carries out, delta 2.
      m = '0; m[105:58] = 48'hFFFFFF800000;
      apply_stimulus(2, m, 100, 2'b01, 1'b1, mk(2'd2, 52'd0, 102, 2'b01, 1'b0, 1'b0));
      wait_drain();

      // FP64, leading one one bit down, fraction 1 plus round bit gives 2, delta 0.
      m = '0; m[104] = 1'b1; m[52] = 1'b1; m[51] = 1'b1;
      apply_stimulus(3, m, 500, 2'b10, 1'b1, mk(2'd3, 52'h2, 500, 2'b10, 1'b0, 1'b0));
      wait_drain();

      m = '0; m[105] = 1'b1; m[104:95] = 10'h155;
      apply_stimulus(1, m, 15, 2'b00, 1'b1, mk(2'd1, 52'h155, 16, 2'b00, 1'b0, 1'b0));
      wait_drain();

      m = '0;
      apply_stimulus(0, m, 7, 2'b10, 1'b1, mk(2'd0, 52'd0, 7, 2'b10, 1'b0, 1'b0));
      wait_drain();

      m = '0; m[105] = 1'b1; m[100] = 1'b1;
      apply_stimulus(1, m, 333, 2'b11, 1'b1, mk(2'd1, 52'd0, 333, 2'b11, 1'b1, 1'b0));
      wait_drain();

      // FP16 at exp 30 with a carry-out round: sum reaches 32.
      m = '0; m[105] = 1'b1; m[104:95] = 10'h3FF; m[94] = 1'b1;
`ifdef ROUND_SCHED_OVF_EN
      apply_stimulus(2, m, 30, 2'b00, 1'b1, mk(2'd2, 52'd0, 31, 2'b00, 1'b0, 1'b1));
`else
      apply_stimulus(2, m, 30, 2'b00, 1'b1, mk(2'd2, 52'd0, 32, 2'b00, 1'b0, 1'b0));
`endif
      wait_drain();

      // All four lanes requesting with out_ready high: grants rotate 0,1,2,3,0,...
      do_reset();
      m = '0; m[105] = 1'b1;
      for (int l = 0; l < 4; l++) set_lane(l, m, 100 + l, 2'b10);
      for (int k = 0; k < 8; k++) sb.push_back(mk(2'(k % 4), 52'd0, 101 + (k % 4), 2'b10, 1'b0, 1'b0));
      req_valid = 4'b1111;
      cnt = 0;
      for (int i = 0; i < 40 && cnt < 8; i++) begin
         @(negedge clk);
         if (|(req_valid & req_ready)) cnt++;
      end
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      check_output("rr_accepts", 64'(cnt), 64'(8));
      wait_drain();
      check_output("rr_results", 64'(out_stamp.size()), 64'(8));
      span = (out_stamp.size() > 0) ? (out_stamp[$] - out_stamp[0]) : -1;
      check_output("rr_span", 64'(span), 64'(7));

      // Stall: two lanes valid, downstream blocked for five cycles.
      do_reset();
      m = '0; m[105] = 1'b1;
      set_lane(1, m, 200, 2'b10);
      m = '0; m[105:58] = 48'hC00000000000;
      set_lane(3, m, 50, 2'b01);
      sb.push_back(mk(2'd1, 52'd0, 201, 2'b10, 1'b0, 1'b0));
      sb.push_back(mk(2'd3, 52'h400000, 51, 2'b01, 1'b0, 1'b0));
      out_ready = 1'b0;
      req_valid = 4'b1010;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (|(req_valid & req_ready)) cnt++;
         if (i >= 2) begin
            check_output("stall_req_ready", 64'(req_ready), 64'(0));
            check_output("stall_out_valid", 64'(out_valid), 64'(1));
            check_output("stall_out_id",    64'(out_id),    64'(1));
            check_output("stall_out_exp",   64'(out_exp),   64'(201));
         end
      end
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      check_output("stall_accepts", 64'(cnt), 64'(2));
      out_ready = 1'b1;
      wait_drain();

      // Reset with a result parked in the output register: it must vanish.
      out_ready = 1'b0;
      m = '0; m[105] = 1'b1;
      apply_stimulus(0, m, 9, 2'b10, 1'b0, dummy);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_output("midrst_out_valid", 64'(out_valid), 64'(0));
      check_output("midrst_req_ready", 64'(req_ready), 64'(0));
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_output("midrst_no_output", 64'(out_valid), 64'(0));

      check_output("sb_empty", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
